rmt_repair_ram: RTL and testbench
=================================

RMT_REPAIR_RAM -- requirements
Module: rmt_repair_ram

Interface
REQ-001 SHALL have parameter DEPTH, default 34: number of map entries (architected registers).
REQ-002 SHALL have parameter INDEX, default 6: address width, 2^INDEX >= DEPTH.
REQ-003 SHALL have parameter WIDTH, default 7: physical-tag width, 2^WIDTH >= DEPTH.
REQ-004 SHALL have parameter WR_PORTS, default 4: dispatch lanes; read ports = 2*WR_PORTS.
REQ-005 SHALL have parameter N_PACKETS, default 8: repair/init writes per cycle.
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port laneActive_i, input, WR_PORTS: per-lane enable.
REQ-009 SHALL have port rdAddr_i, input, 2*WR_PORTS*INDEX: read addresses; ports 2k and 2k+1 belong to lane k.
REQ-010 SHALL have port rdData_o, output, 2*WR_PORTS*WIDTH: read data.
REQ-011 SHALL have port wrEn_i, input, WR_PORTS: dispatch write enables.
REQ-012 SHALL have port wrAddr_i, input, WR_PORTS*INDEX: dispatch write addresses.
REQ-013 SHALL have port wrData_i, input, WR_PORTS*WIDTH: dispatch write data.
REQ-014 SHALL have port repairStart_i, input, 1: request to enter repair.
REQ-015 SHALL have port repairValid_i, input, N_PACKETS: per-packet valid.
REQ-016 SHALL have port repairAddr_i, input, N_PACKETS*INDEX: repair addresses.
REQ-017 SHALL have port repairData_i, input, N_PACKETS*WIDTH: repair data.
REQ-018 SHALL have port repairLast_i, input, 1: final repair beat.
REQ-019 SHALL have port ready_o, output, 1: high only in READY state.
REQ-020 SHALL have port repairBusy_o, output, 1: high only in REPAIR state.

Function
REQ-021 SHALL implement FSM states INIT, READY, REPAIR; ready_o and repairBusy_o SHALL be decoded from registered state.
REQ-022 In INIT, an init counter (reset 0) SHALL write ram[c+j]=c+j for j<N_PACKETS with c+j<DEPTH each cycle, then advance by N_PACKETS.
REQ-023 INIT SHALL go to READY on the cycle after the write in which c+N_PACKETS>=DEPTH; INIT lasts ceil(DEPTH/N_PACKETS) cycles.
REQ-024 Reads SHALL be combinational from the array; writes SHALL become visible the cycle after the clock edge, with no bypass.
REQ-025 A read on an inactive lane, at an address >=DEPTH, or in INIT SHALL return 0.
REQ-026 In READY with repairStart_i low, each lane k with wrEn_i[k] and laneActive_i[k] high and wrAddr<DEPTH SHALL write.
REQ-027 When several lanes write the same address in one cycle, the highest lane index SHALL win.
REQ-028 repairStart_i high in READY SHALL move the FSM to REPAIR next cycle and drop all dispatch writes in that cycle.
REQ-029 In REPAIR, every packet j with repairValid_i[j] high and addr<DEPTH SHALL be written; on address collision the highest j SHALL win.
REQ-030 In REPAIR, dispatch writes SHALL be ignored.
REQ-031 repairLast_i high in REPAIR SHALL commit that cycle's packets and move the FSM to READY next cycle.
REQ-032 repairStart_i, repairValid_i and repairLast_i SHALL be ignored in INIT.
REQ-033 repairValid_i and repairLast_i SHALL be ignored in READY.
REQ-034 repairStart_i SHALL be ignored in REPAIR.
REQ-035 A repair of any length, from 1 beat to unbounded, SHALL be supported.

Reset
REQ-036 reset low SHALL asynchronously force state=INIT, counter=0, ready_o=0 and repairBusy_o=0.
REQ-037 Array contents SHALL not be reset directly; the INIT sweep SHALL restore them.
REQ-038 Assertion of reset mid-REPAIR or mid-INIT SHALL abandon the operation and restart INIT after release.

Verification
REQ-039 Release reset with defaults -> ready_o rises after 5 cycles; every rdData equals its address (e.g. addr 33 -> 33).
REQ-040 READY: lanes 1 and 3 both write addr 5, data 40 and 41 -> rdData for addr 5 = 41 next cycle; lane 2 inactive with wrEn high -> no write.
REQ-041 repairStart_i pulse with lane 0 writing addr 2=50 -> addr 2 unchanged; repairBusy_o=1 next cycle, ready_o=0.
REQ-042 REPAIR: beat 1 writes packets {3->60, 3->61 (j higher)}; beat 2 writes {7->62} with repairLast_i -> addr 3=61, addr 7=62; ready_o=1 after beat 2.
REQ-043 Assert reset during a REPAIR beat -> repairBusy_o=0 immediately; after release, INIT re-runs and addr 3 reads 3.
REQ-044 Write or repair to addr 40 (>=DEPTH) -> no array change; read of addr 40 returns 0.

Source files
------------

// File: rtl/rmt_repair_ram_if.sv
// Bundles the dispatch, read, repair and status signals of rmt_repair_ram.
// slave  : seen by the RAM (dispatch/read/repair inputs, read data and status outputs)
// master : seen by the driver of the RAM (the mirror image)
//   laneActive_i   per-lane enable (gates reads and dispatch writes)
//   rdAddr_i/rdData_o   2*WR_PORTS read ports; ports 2k and 2k+1 belong to lane k
//   wrEn_i/wrAddr_i/wrData_i   dispatch writes, one per lane
//   repairStart_i/repairValid_i/repairAddr_i/repairData_i/repairLast_i   repair beats
//   ready_o/repairBusy_o   registered-state status flags
interface rmt_repair_ram_if #(
    parameter int unsigned INDEX     = 6,
    parameter int unsigned WIDTH     = 7,
    parameter int unsigned WR_PORTS  = 4,
    parameter int unsigned N_PACKETS = 8
);
    logic [WR_PORTS-1:0]           laneActive_i;
    logic [2*WR_PORTS*INDEX-1:0]   rdAddr_i;
    logic [2*WR_PORTS*WIDTH-1:0]   rdData_o;
    logic [WR_PORTS-1:0]           wrEn_i;
    logic [WR_PORTS*INDEX-1:0]     wrAddr_i;
    logic [WR_PORTS*WIDTH-1:0]     wrData_i;
    logic                          repairStart_i;
    logic [N_PACKETS-1:0]          repairValid_i;
    logic [N_PACKETS*INDEX-1:0]    repairAddr_i;
    logic [N_PACKETS*WIDTH-1:0]    repairData_i;
    logic                          repairLast_i;
    logic                          ready_o;
    logic                          repairBusy_o;

    modport slave (
        input  laneActive_i, rdAddr_i, wrEn_i, wrAddr_i, wrData_i,
        input  repairStart_i, repairValid_i, repairAddr_i, repairData_i, repairLast_i,
        output rdData_o, ready_o, repairBusy_o
    );

    modport master (
        output laneActive_i, rdAddr_i, wrEn_i, wrAddr_i, wrData_i,
        output repairStart_i, repairValid_i, repairAddr_i, repairData_i, repairLast_i,
        input  rdData_o, ready_o, repairBusy_o
    );
endinterface

// File: rtl/rmt_repair_ram.sv
// Rename-map table RAM with a self-initialising sweep and a multi-beat repair mode.
// Ports:
//   clk    sole clock, rising edge
//   reset  asynchronous active-low reset (forces INIT, clears init counter)
//   bus    rmt_repair_ram_if.slave: dispatch writes, combinational reads, repair beats,
//          ready_o (READY state) and repairBusy_o (REPAIR state)
module rmt_repair_ram #(
    parameter int unsigned DEPTH     = 34,
    parameter int unsigned INDEX     = 6,
    parameter int unsigned WIDTH     = 7,
    parameter int unsigned WR_PORTS  = 4,
    parameter int unsigned N_PACKETS = 8
) (
    input logic            clk,
    input logic            reset,
    rmt_repair_ram_if.slave bus
);
    typedef enum logic [1:0] {S_INIT, S_READY, S_REPAIR} state_e;

    localparam int unsigned CW = $clog2(DEPTH + N_PACKETS + 1);

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]       ram_q [DEPTH];
    logic [WIDTH-1:0]       ram_d [DEPTH];
    logic [2*WR_PORTS*WIDTH-1:0] rd_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_INIT: begin
                cnt_d = cnt_q + CW'(N_PACKETS);
                if (32'(cnt_q) + N_PACKETS >= DEPTH) begin
                    state_d = S_READY;
                    cnt_d   = '0;
                end
            end
            S_READY:  if (bus.repairStart_i) state_d = S_REPAIR;
            S_REPAIR: if (bus.repairLast_i)  state_d = S_READY;
            default:  state_d = S_INIT;
        endcase
    end

    // Writes are decoded per entry; later loop iterations override earlier
    // ones, so the highest lane / packet index wins on an address collision.
    // Addresses >= DEPTH simply match no entry.
    always_comb begin
        for (int unsigned e = 0; e < DEPTH; e++) begin
            ram_d[e] = ram_q[e];
            if (state_q == S_INIT && e >= 32'(cnt_q) && e < 32'(cnt_q) + N_PACKETS)
                ram_d[e] = WIDTH'(e);
            for (int unsigned k = 0; k < WR_PORTS; k++) begin
                if (state_q == S_READY && !bus.repairStart_i && bus.wrEn_i[k] &&
                    bus.laneActive_i[k] && bus.wrAddr_i[k*INDEX +: INDEX] == INDEX'(e))
                    ram_d[e] = bus.wrData_i[k*WIDTH +: WIDTH];
            end
            for (int unsigned j = 0; j < N_PACKETS; j++) begin
                if (state_q == S_REPAIR && bus.repairValid_i[j] &&
                    bus.repairAddr_i[j*INDEX +: INDEX] == INDEX'(e))
                    ram_d[e] = bus.repairData_i[j*WIDTH +: WIDTH];
            end
        end
    end

    // Contents are deliberately not reset; the INIT sweep rebuilds them.
    always_ff @(posedge clk) begin
        ram_q <= ram_d;
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned p = 0; p < 2*WR_PORTS; p++) begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                if (state_q != S_INIT && bus.laneActive_i[p/2] &&
                    bus.rdAddr_i[p*INDEX +: INDEX] == INDEX'(e))
                    rd_data[p*WIDTH +: WIDTH] = ram_q[e];
            end
        end
    end

    assign bus.rdData_o     = rd_data;
    assign bus.ready_o      = (state_q == S_READY);
    assign bus.repairBusy_o = (state_q == S_REPAIR);
endmodule

// File: tb/tb_rmt_repair_ram.sv
module tb_rmt_repair_ram;
    localparam int unsigned DEPTH = 34, INDEX = 6, WIDTH = 7, WRP = 4, NP = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rmt_repair_ram_if #(.INDEX(INDEX), .WIDTH(WIDTH), .WR_PORTS(WRP), .N_PACKETS(NP)) bus ();

    rmt_repair_ram #(.DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH), .WR_PORTS(WRP), .N_PACKETS(NP))
        dut (.clk(clk), .reset(reset), .bus(bus));

    // kind: 0 = read port data, 1 = ready_o, 2 = repairBusy_o
    typedef struct {
        string name;
        int    kind;
        int    port;
        int    exp;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Monitor: consumes every queued expectation at the falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            int   act;
            e = exp_q.pop_front();
            case (e.kind)
                0:       act = int'(bus.rdData_o[e.port*WIDTH +: WIDTH]);
                1:       act = int'(bus.ready_o);
                default: act = int'(bus.repairBusy_o);
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %0d expected %0d", e.name, act, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input int a);
        bus.rdAddr_i[p*INDEX +: INDEX] = INDEX'(a);
    endtask

    task automatic exp_rd(input string n, input int p, input int v);
        exp_t e;
        e.name = n; e.kind = 0; e.port = p; e.exp = v;
        exp_q.push_back(e);
    endtask

    task automatic exp_flag(input string n, input int kind, input int v);
        exp_t e;
        e.name = n; e.kind = kind; e.port = 0; e.exp = v;
        exp_q.push_back(e);
    endtask

    task automatic set_wr(input int k, input int a, input int d);
        bus.wrEn_i[k] = 1'b1;
        bus.wrAddr_i[k*INDEX +: INDEX] = INDEX'(a);
        bus.wrData_i[k*WIDTH +: WIDTH] = WIDTH'(d);
    endtask

    task automatic set_pkt(input int j, input int a, input int d);
        bus.repairValid_i[j] = 1'b1;
        bus.repairAddr_i[j*INDEX +: INDEX] = INDEX'(a);
        bus.repairData_i[j*WIDTH +: WIDTH] = WIDTH'(d);
    endtask

    task automatic clear_in();
        bus.wrEn_i        = '0;
        bus.wrAddr_i      = '0;
        bus.wrData_i      = '0;
        bus.repairStart_i = 1'b0;
        bus.repairValid_i = '0;
        bus.repairAddr_i  = '0;
        bus.repairData_i  = '0;
        bus.repairLast_i  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_in();
        bus.laneActive_i = '1;
        bus.rdAddr_i     = '0;

        // In reset: flags low, reads return 0.
        tick();
        set_rd(0, 5);
        exp_flag("rst_ready", 1, 0);
        exp_flag("rst_busy", 2, 0);
        exp_rd("rst_read", 0, 0);
        settle();

        // INIT lasts ceil(34/8) = 5 cycles; repairStart ignored during INIT.
        tick();
        reset = 1'b1;
        bus.repairStart_i = 1'b1;
        repeat (4) tick();
        exp_flag("init4_ready", 1, 0);
        exp_flag("init4_busy", 2, 0);
        exp_rd("init_read", 0, 0);
        settle();
        tick();
        bus.repairStart_i = 1'b0;
        exp_flag("init5_ready", 1, 1);
        exp_flag("init5_busy", 2, 0);
        settle();

        // Sweep addresses 0..39: identity below DEPTH, 0 beyond.
        for (int g = 0; g < 5; g++) begin
            for (int p = 0; p < 8; p++) begin
                set_rd(p, g*8 + p);
                exp_rd($sformatf("sweep_a%0d", g*8 + p), p, (g*8 + p < 34) ? g*8 + p : 0);
            end
            settle();
        end

        // Lane 2 inactive: its read ports return 0, its write is dropped.
        // Lanes 0,1,3 write addr 5; lane 3 wins. No bypass before the edge.
        tick();
        bus.laneActive_i = 4'b1011;
        set_wr(0, 5, 39);
        set_wr(1, 5, 40);
        set_wr(2, 6, 99);
        set_wr(3, 5, 41);
        set_rd(0, 5);
        set_rd(1, 6);
        set_rd(4, 10);
        set_rd(5, 11);
        set_rd(6, 12);
        exp_rd("nobypass_a5", 0, 5);
        exp_rd("inactive_p4", 4, 0);
        exp_rd("inactive_p5", 5, 0);
        exp_rd("active_p6", 6, 12);
        settle();
        tick();
        clear_in();
        exp_rd("lane_prio_a5", 0, 41);
        exp_rd("inactive_wr_a6", 1, 6);
        settle();

        // Out-of-range dispatch write: no change, read of 40 returns 0.
        bus.laneActive_i = '1;
        tick();
        set_wr(0, 40, 7);
        tick();
        clear_in();
        set_rd(0, 40);
        set_rd(1, 8);
        set_rd(2, 33);
        exp_rd("oob_rd40", 0, 0);
        exp_rd("oob_a8", 1, 8);
        exp_rd("oob_a33", 2, 33);
        settle();

        // Repair start drops that cycle's dispatch write.
        tick();
        bus.repairStart_i = 1'b1;
        set_wr(0, 2, 50);
        tick();
        clear_in();
        set_rd(0, 2);
        exp_rd("start_drop_a2", 0, 2);
        exp_flag("start_busy", 2, 1);
        exp_flag("start_ready", 1, 0);
        settle();

        // Beat 1: packets 3->60, 3->61; dispatch write and repairStart ignored.
        tick();
        set_pkt(0, 3, 60);
        set_pkt(1, 3, 61);
        set_wr(0, 9, 70);
        bus.repairStart_i = 1'b1;
        tick();
        clear_in();
        set_rd(0, 3);
        set_rd(1, 9);
        exp_rd("beat1_a3", 0, 61);
        exp_rd("rep_nodisp_a9", 1, 9);
        exp_flag("beat1_busy", 2, 1);
        settle();

        // Beat 2 (last): 7->62 plus an out-of-range packet.
        tick();
        set_pkt(0, 7, 62);
        set_pkt(2, 40, 5);
        bus.repairLast_i = 1'b1;
        tick();
        clear_in();
        set_rd(0, 3);
        set_rd(1, 7);
        set_rd(2, 40);
        exp_rd("beat2_a3", 0, 61);
        exp_rd("beat2_a7", 1, 62);
        exp_rd("beat2_rd40", 2, 0);
        exp_flag("last_ready", 1, 1);
        exp_flag("last_busy", 2, 0);
        settle();

        // READY ignores repairValid/repairLast.
        tick();
        set_pkt(0, 10, 77);
        bus.repairLast_i = 1'b1;
        tick();
        clear_in();
        set_rd(0, 10);
        exp_rd("ready_norep_a10", 0, 10);
        exp_flag("ready_stay", 1, 1);
        settle();

        // Reset mid-REPAIR: busy drops at once; INIT restores identity map.
        tick();
        bus.repairStart_i = 1'b1;
        tick();
        clear_in();
        set_pkt(0, 3, 90);
        #2;
        reset = 1'b0;
        exp_flag("midrep_rst_busy", 2, 0);
        exp_flag("midrep_rst_ready", 1, 0);
        settle();
        clear_in();
        repeat (2) tick();
        reset = 1'b1;
        repeat (5) tick();
        set_rd(0, 3);
        set_rd(1, 5);
        set_rd(2, 7);
        set_rd(3, 33);
        exp_flag("reinit_ready", 1, 1);
        exp_rd("reinit_a3", 0, 3);
        exp_rd("reinit_a5", 1, 5);
        exp_rd("reinit_a7", 2, 7);
        exp_rd("reinit_a33", 3, 33);
        settle();

        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
